// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: pixel-clock divider, 10-bit h/v counters, registered sync/enable
// decodes and a run/drain/idle controller that only ever stops on a frame boundary.
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [9:0] hor_cnt,
  output logic [9:0] ver_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_S  = 11'(H_ACT_START);
  localparam logic [10:0] H_ACT_E  = 11'(H_ACT_END);
  localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_S  = 11'(V_ACT_START);
  localparam logic [10:0] V_ACT_E  = 11'(V_ACT_END);

  logic [1:0]  state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [9:0]  hor_q, hor_d;
  logic [9:0]  ver_q, ver_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic        tick, line_end, frame_end, active_d;
  logic [10:0] hor_x, ver_x;

  always_comb begin
    tick      = (state_q != S_IDLE) && (div_q == DIV_LAST);
    line_end  = tick && (hor_q == H_LAST);
    frame_end = line_end && (ver_q == V_LAST);

    state_d = state_q;
    fs_d    = 1'b0;
    div_d   = div_q;
    hor_d   = hor_q;
    ver_d   = ver_q;

    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + 4'd1;
      if (tick)     hor_d = line_end  ? '0 : hor_q + 10'd1;
      if (line_end) ver_d = frame_end ? '0 : ver_q + 10'd1;
    end

    // run sampled on the frame-end tick alone decides restart versus stop,
    // so a frame is never started and then immediately abandoned.
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_RUN;
          fs_d    = 1'b1;
        end
      end
      S_RUN, S_DRAIN: begin
        if (frame_end) begin
          if (run) begin
            state_d = S_RUN;
            fs_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = run ? S_RUN : S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      div_d = '0;
      hor_d = '0;
      ver_d = '0;
    end

    // Decode the next counter values so the registered strobes line up with the counters.
    active_d = (state_d != S_IDLE);
    hor_x    = {1'b0, hor_d};
    ver_x    = {1'b0, ver_d};
    hsync_d  = !(active_d && (hor_x < H_SYNC_W));
    vsync_d  = !(active_d && (ver_x < V_SYNC_W));
    de_d     = active_d && (hor_x >= H_ACT_S) && (hor_x < H_ACT_E)
                        && (ver_x >= V_ACT_S) && (ver_x < V_ACT_E);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      hor_q   <= '0;
      ver_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hor_q   <= hor_d;
      ver_q   <= ver_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign hor_cnt     = hor_q;
  assign ver_cnt     = ver_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_en  = de_q;
  assign pix_tick    = tick;
  assign frame_start = fs_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced 20x12 raster: per-cycle scoreboard against an
// elapsed-clock model, a reset/start vector table, and hand-written frame-boundary sequences.
module tb_vga_timing_ctrl;

  localparam int D   = 2;
  localparam int HT  = 20;
  localparam int HS  = 3;
  localparam int HAS = 5;
  localparam int HAE = 17;
  localparam int VT  = 12;
  localparam int VS  = 2;
  localparam int VAS = 3;
  localparam int VAE = 10;
  localparam int FRAME = D * HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [9:0] hor_cnt, ver_cnt;
  logic       hsync, vsync, display_en, pix_tick, frame_start, busy;

  vga_timing_ctrl #(
    .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .hor_cnt(hor_cnt), .ver_cnt(ver_cnt), .hsync(hsync), .vsync(vsync),
    .display_en(display_en), .pix_tick(pix_tick), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] hor;
    logic [9:0] ver;
    logic       hs;
    logic       vs;
    logic       de;
    logic       pix;
    logic       fs;
    logic       bsy;
  } obs_t;

  typedef struct {
    logic rst;
    logic run;
    obs_t exp;
  } vec_t;

  int checks = 0;
  int passed = 0;

  function automatic obs_t cur_obs();
    return '{hor_cnt, ver_cnt, hsync, vsync, display_en, pix_tick, frame_start, busy};
  endfunction

  function automatic vec_t mk(logic r, logic rn, int h, int v, logic hs_, logic vs_,
                              logic de_, logic pix_, logic fs_, logic b_);
    vec_t t;
    t.rst = r;
    t.run = rn;
    t.exp = '{10'(h), 10'(v), hs_, vs_, de_, pix_, fs_, b_};
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: clocks elapsed since the start of the current frame.
  obs_t sb_q[$];
  bit   m_valid = 0;
  bit   m_busy  = 0;
  bit   m_fs    = 0;
  int   m_k     = 0;

  always @(posedge clk) begin
    obs_t e;
    int   h, v;
    if (!reset) begin
      m_valid = 1; m_busy = 0; m_k = 0; m_fs = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (run) begin m_busy = 1; m_k = 0; m_fs = 1; end
        else m_fs = 0;
      end else if (m_k == FRAME - 1) begin
        if (run) begin m_k = 0; m_fs = 1; end
        else begin m_busy = 0; m_k = 0; m_fs = 0; end
      end else begin
        m_k++; m_fs = 0;
      end
    end
    if (m_valid) begin
      h = m_busy ? (m_k / D) % HT : 0;
      v = m_busy ? m_k / (D * HT) : 0;
      e.hor = 10'(h);
      e.ver = 10'(v);
      e.hs  = !(m_busy && h < HS);
      e.vs  = !(m_busy && v < VS);
      e.de  = m_busy && h >= HAS && h < HAE && v >= VAS && v < VAE;
      e.pix = m_busy && (m_k % D == D - 1);
      e.fs  = m_fs;
      e.bsy = m_busy;
      sb_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = cur_obs();
      checks++;
      if (a === e) passed++;
      else $display("FAIL scoreboard t=%0t: got hor=%0d ver=%0d hs/vs/de/pix/fs/busy=%b, expected hor=%0d ver=%0d hs/vs/de/pix/fs/busy=%b",
                    $time, a.hor, a.ver, a[5:0], e.hor, e.ver, e[5:0]);
    end
  end

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(hor_cnt == 10'(h) && ver_cnt == 10'(v)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      $display("FAIL wait_pos(%0d,%0d) timeout: at hor=%0d ver=%0d", h, v, hor_cnt, ver_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];

  initial begin
    int n, hs_low, vs_low, de_cnt, hmin, hmax, vmin, vmax;
    obs_t a;

    // Reset held 3 clocks with run=1, then release and watch the first pixels.
    tbl[0]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[5]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 1, 2, 0, 0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 0, 3, 0, 1, 0, 0, 1, 0, 1);
    tbl[11] = mk(1, 0, 4, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst;
      run   = tbl[i].run;
      @(posedge clk);
      @(negedge clk);
      a = cur_obs();
      checks++;
      if (a === tbl[i].exp) passed++;
      else $display("FAIL vector %0d: got %h expected %h", i, a, tbl[i].exp);
    end

    // Back to RUN from DRAIN, then measure one complete frame.
    run = 1;
    n = 0;
    while (!frame_start && n < 2000) begin @(negedge clk); n++; end
    chk("first frame_start seen", int'(frame_start), 1);
    n = 0; hs_low = 0; vs_low = 0; de_cnt = 0;
    hmin = 1023; hmax = 0; vmin = 1023; vmax = 0;
    do begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (display_en) begin
        de_cnt++;
        if (hor_cnt < hmin) hmin = hor_cnt;
        if (hor_cnt > hmax) hmax = hor_cnt;
        if (ver_cnt < vmin) vmin = ver_cnt;
        if (ver_cnt > vmax) vmax = ver_cnt;
      end
      n++;
      @(negedge clk);
    end while (!frame_start && n < 2000);
    chk("frame period clocks", n, FRAME);
    chk("hsync low clocks/frame", hs_low, HS * D * VT);
    chk("vsync low clocks/frame", vs_low, VS * HT * D);
    chk("display_en clocks/frame", de_cnt, (HAE - HAS) * D * (VAE - VAS));
    chk("display_en first hor", hmin, HAS);
    chk("display_en last hor", hmax, HAE - 1);
    chk("display_en first ver", vmin, VAS);
    chk("display_en last ver", vmax, VAE - 1);
    chk("wrap hor", int'(hor_cnt), 0);
    chk("wrap ver", int'(ver_cnt), 0);
    @(negedge clk);
    chk("frame_start one clock", int'(frame_start), 0);

    // Line wrap carries into ver_cnt.
    wait_pos(HT - 1, 4);
    @(negedge clk);
    chk("line end pix_tick", int'(pix_tick), 1);
    @(negedge clk);
    chk("line wrap hor", int'(hor_cnt), 0);
    chk("line wrap ver", int'(ver_cnt), 5);

    // Stop request mid-frame drains to the frame end.
    wait_pos(10, 6);
    run = 0;
    @(negedge clk);
    chk("drain busy", int'(busy), 1);
    wait_pos(HT - 1, VT - 1);
    @(negedge clk);
    chk("drain last tick busy", int'(busy), 1);
    @(negedge clk);
    chk("idle busy", int'(busy), 0);
    chk("idle hor", int'(hor_cnt), 0);
    chk("idle ver", int'(ver_cnt), 0);
    chk("idle no frame_start", int'(frame_start), 0);
    chk("idle hsync", int'(hsync), 1);
    chk("idle vsync", int'(vsync), 1);
    repeat (5) @(negedge clk);
    chk("idle held busy", int'(busy), 0);
    chk("idle held hor", int'(hor_cnt), 0);

    // Restart, then drop and re-raise run inside the frame.
    run = 1;
    @(negedge clk);
    chk("restart frame_start", int'(frame_start), 1);
    chk("restart busy", int'(busy), 1);
    wait_pos(0, 3);
    run = 0;
    wait_pos(0, 8);
    chk("resume busy in drain", int'(busy), 1);
    run = 1;
    wait_pos(HT - 1, VT - 1);
    @(negedge clk);
    @(negedge clk);
    chk("resume frame_start", int'(frame_start), 1);
    chk("resume busy", int'(busy), 1);

    // run=0 sampled on the frame-end tick while in RUN: stop, no restart.
    wait_pos(HT - 1, VT - 1);
    @(negedge clk);
    run = 0;
    @(negedge clk);
    chk("end-tick stop busy", int'(busy), 0);
    chk("end-tick stop frame_start", int'(frame_start), 0);

    // run=1 sampled on the frame-end tick while in DRAIN: wrap with frame_start.
    run = 1;
    @(negedge clk);
    chk("start after stop", int'(frame_start), 1);
    wait_pos(0, 5);
    run = 0;
    wait_pos(HT - 1, VT - 1);
    @(negedge clk);
    run = 1;
    @(negedge clk);
    chk("drain end-tick resume frame_start", int'(frame_start), 1);
    chk("drain end-tick resume busy", int'(busy), 1);

    // Reset mid-frame.
    wait_pos(10, 7);
    reset = 0;
    @(negedge clk);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset hor", int'(hor_cnt), 0);
    chk("mid reset ver", int'(ver_cnt), 0);
    chk("mid reset hsync", int'(hsync), 1);
    chk("mid reset frame_start", int'(frame_start), 0);
    reset = 1;
    @(negedge clk);
    chk("post reset frame_start", int'(frame_start), 1);
    chk("post reset busy", int'(busy), 1);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
